sequenciador_fases: RTL and testbench

- Controls one shared `contador_m` timebase (M ticks per `fim` pulse) to run a three-phase preparation cycle: grind (moer), heat (aquecer), pour (despejar).
- Each phase lasts a programmed number of timer periods.
- Drives the counter's `zera_s` and `conta` inputs, consumes its `fim` output, and exposes phase strobes and status to the top-level machine FSM.

---
 rtl/sequenciador_fases.sv | 186 ++++++++++++++++++
 tb/tb_sequenciador_fases.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_fases.sv
`default_nettype none
// ============================================================================
// Module      : sequenciador_fases
// Description : Three-phase (moer/aquecer/despejar) sequencer driving one
//               shared contador_m timebase. Optional macro
//               SEQUENCIADOR_PAUSA_EN adds a `pausar` input.
// Revision    : 1.0 - initial release
// ============================================================================
module sequenciador_fases #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         iniciar,
    input  logic         cancelar,
    input  logic [W-1:0] dur_moer,
    input  logic [W-1:0] dur_aquecer,
    input  logic [W-1:0] dur_despejar,
    input  logic         fim_contador,
`ifdef SEQUENCIADOR_PAUSA_EN
    input  logic         pausar,
`endif
    output logic         zera_contador,
    output logic         conta_contador,
    output logic         fase_moer,
    output logic         fase_aquecer,
    output logic         fase_despejar,
    output logic         ocupado,
    output logic         pronto,
    output logic [3:0]   db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ZERA1    = 4'd1,
        MOER     = 4'd2,
        ZERA2    = 4'd3,
        AQUECER  = 4'd4,
        ZERA3    = 4'd5,
        DESPEJAR = 4'd6,
        FINAL    = 4'd7,
        CANCELA  = 4'd8
    } estado_t;

    localparam logic [W-1:0] c_um   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_zero = '0;

    estado_t        r_estado;
    logic [W-1:0]   r_fase_cnt;
    logic [W-1:0]   r_dur_moer;
    logic [W-1:0]   r_dur_aquecer;
    logic [W-1:0]   r_dur_despejar;
    logic           r_zera;
    logic           r_conta;
    logic           r_moer;
    logic           r_aquecer;
    logic           r_despejar;
    logic           r_ocupado;
    logic           r_pronto;

    estado_t        w_prox;
    estado_t        w_saida;
    logic [W-1:0]   w_prox_cnt;
    logic [W-1:0]   w_dur;
    logic [W-1:0]   w_prox_dur;
    logic           w_ultimo;
    logic           w_pausa;

`ifdef SEQUENCIADOR_PAUSA_EN
    assign w_pausa = pausar;
`else
    assign w_pausa = 1'b0;
`endif

    always_comb begin
        w_dur   = c_zero;
        w_saida = INICIAL;
        case (r_estado)
            MOER:     begin w_dur = r_dur_moer;     w_saida = ZERA2;    end
            AQUECER:  begin w_dur = r_dur_aquecer;  w_saida = ZERA3;    end
            DESPEJAR: begin w_dur = r_dur_despejar; w_saida = FINAL;    end
            default:  begin w_dur = c_zero;         w_saida = INICIAL;  end
        endcase
    end

    // A zero-length phase spends one idle cycle; otherwise leave on the D-th fim.
    assign w_ultimo = (w_dur == c_zero) ||
                      (fim_contador && (r_fase_cnt == (w_dur - c_um)));

    always_comb begin
        w_prox     = r_estado;
        w_prox_cnt = r_fase_cnt;
        case (r_estado)
            INICIAL: begin
                if (iniciar && !cancelar) begin
                    w_prox = ZERA1;
                end
            end
            ZERA1: begin
                w_prox     = MOER;
                w_prox_cnt = c_zero;
            end
            ZERA2: begin
                w_prox     = AQUECER;
                w_prox_cnt = c_zero;
            end
            ZERA3: begin
                w_prox     = DESPEJAR;
                w_prox_cnt = c_zero;
            end
            MOER, AQUECER, DESPEJAR: begin
                if (!w_pausa) begin
                    if (w_ultimo) begin
                        w_prox = w_saida;
                    end else if (fim_contador) begin
                        w_prox_cnt = r_fase_cnt + c_um;
                    end
                end
            end
            FINAL:   w_prox = INICIAL;
            CANCELA: w_prox = INICIAL;
            default: w_prox = INICIAL;
        endcase

        // Abort beats every other transition, including a phase exit.
        if (cancelar && (r_estado != INICIAL) && (r_estado != CANCELA) &&
            (r_estado <= FINAL)) begin
            w_prox = CANCELA;
        end
    end

    always_comb begin
        case (w_prox)
            MOER:     w_prox_dur = r_dur_moer;
            AQUECER:  w_prox_dur = r_dur_aquecer;
            DESPEJAR: w_prox_dur = r_dur_despejar;
            default:  w_prox_dur = c_zero;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_estado.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado       <= INICIAL;
            r_fase_cnt     <= c_zero;
            r_dur_moer     <= c_zero;
            r_dur_aquecer  <= c_zero;
            r_dur_despejar <= c_zero;
            r_zera         <= 1'b0;
            r_conta        <= 1'b0;
            r_moer         <= 1'b0;
            r_aquecer      <= 1'b0;
            r_despejar     <= 1'b0;
            r_ocupado      <= 1'b0;
            r_pronto       <= 1'b0;
        end else begin
            r_estado   <= w_prox;
            r_fase_cnt <= w_prox_cnt;
            if ((r_estado == INICIAL) && (w_prox == ZERA1)) begin
                r_dur_moer     <= dur_moer;
                r_dur_aquecer  <= dur_aquecer;
                r_dur_despejar <= dur_despejar;
            end
            r_zera     <= (w_prox == ZERA1) || (w_prox == ZERA2) || (w_prox == ZERA3) ||
                          (w_prox == FINAL) || (w_prox == CANCELA);
            r_conta    <= ((w_prox == MOER) || (w_prox == AQUECER) || (w_prox == DESPEJAR)) &&
                          (w_prox_dur != c_zero);
            r_moer     <= (w_prox == MOER);
            r_aquecer  <= (w_prox == AQUECER);
            r_despejar <= (w_prox == DESPEJAR);
            r_ocupado  <= (w_prox != INICIAL);
            r_pronto   <= (w_prox == FINAL);
        end
    end

    assign zera_contador  = r_zera;
    assign conta_contador = r_conta & ~w_pausa;
    assign fase_moer      = r_moer;
    assign fase_aquecer   = r_aquecer;
    assign fase_despejar  = r_despejar;
    assign ocupado        = r_ocupado;
    assign pronto         = r_pronto;
    assign db_estado      = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_fases.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sequenciador_fases
// Description : Scoreboard bench for sequenciador_fases with a contador_m
//               model (M=5); pause case only when SEQUENCIADOR_PAUSA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequenciador_fases;

    localparam int W = 8;
    localparam int M = 5;

    typedef struct packed {
        logic [3:0] est;
        logic       zera;
        logic       conta;
        logic       moer;
        logic       aq;
        logic       desp;
        logic       ocup;
        logic       pronto;
    } obs_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         iniciar = 1'b0;
    logic         cancelar = 1'b0;
    logic         pausar = 1'b0;
    logic [W-1:0] dur_moer = '0;
    logic [W-1:0] dur_aquecer = '0;
    logic [W-1:0] dur_despejar = '0;
    logic         fim_contador;
    logic         zera_contador;
    logic         conta_contador;
    logic         fase_moer;
    logic         fase_aquecer;
    logic         fase_despejar;
    logic         ocupado;
    logic         pronto;
    logic [3:0]   db_estado;

    logic [2:0]   r_q_cont;
    logic         fim_forca = 1'b0;
    obs_t         obs;
    obs_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    sequenciador_fases #(.W(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .cancelar       (cancelar),
        .dur_moer       (dur_moer),
        .dur_aquecer    (dur_aquecer),
        .dur_despejar   (dur_despejar),
        .fim_contador   (fim_contador),
`ifdef SEQUENCIADOR_PAUSA_EN
        .pausar         (pausar),
`endif
        .zera_contador  (zera_contador),
        .conta_contador (conta_contador),
        .fase_moer      (fase_moer),
        .fase_aquecer   (fase_aquecer),
        .fase_despejar  (fase_despejar),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // External contador_m: mod-M, synchronous clear, fim while at M-1.
    always_ff @(posedge clock) begin
        if (reset || zera_contador)
            r_q_cont <= 3'd0;
        else if (conta_contador)
            r_q_cont <= (r_q_cont == 3'(M-1)) ? 3'd0 : r_q_cont + 3'd1;
    end
    assign fim_contador = (r_q_cont == 3'(M-1)) | fim_forca;

    assign obs = {db_estado, zera_contador, conta_contador, fase_moer,
                  fase_aquecer, fase_despejar, ocupado, pronto};

    function automatic obs_t mk(input logic [3:0] est, input logic conta);
        obs_t o;
        o.est    = est;
        o.zera   = (est == 4'd1) || (est == 4'd3) || (est == 4'd5) ||
                   (est == 4'd7) || (est == 4'd8);
        o.conta  = conta;
        o.moer   = (est == 4'd2);
        o.aq     = (est == 4'd4);
        o.desp   = (est == 4'd6);
        o.ocup   = (est != 4'd0);
        o.pronto = (est == 4'd7);
        return o;
    endfunction

    task automatic chk(input string tag, input obs_t got, input obs_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got estado=%0d outs=%b, expected estado=%0d outs=%b",
                     tag, got.est, got[6:0], want.est, want[6:0]);
        end
    endtask

    task automatic push_fase(input logic [3:0] est, input int d, input int p_at, input int p_len);
        if (d == 0) begin
            exp_q.push_back(mk(est, 1'b0));
        end else begin
            for (int r = 0; r < d * M + p_len; r++) begin
                exp_q.push_back(mk(est, !((p_len > 0) && (r >= p_at) && (r < p_at + p_len))));
            end
        end
    endtask

    task automatic push_run(input int d1, input int d2, input int d3, input int p_at, input int p_len);
        exp_q.push_back(mk(4'd1, 1'b0));
        push_fase(4'd2, d1, p_at, p_len);
        exp_q.push_back(mk(4'd3, 1'b0));
        push_fase(4'd4, d2, 0, 0);
        exp_q.push_back(mk(4'd5, 1'b0));
        push_fase(4'd6, d3, 0, 0);
        exp_q.push_back(mk(4'd7, 1'b0));
        exp_q.push_back(mk(4'd0, 1'b0));
        exp_q.push_back(mk(4'd0, 1'b0));
    endtask

    task automatic run_case(input string tag, input int d1, input int d2, input int d3,
                            input bit hold, input bit muda_dur, input int cancel_at,
                            input int reset_at, input int p_at, input int p_len);
        obs_t e;
        int   idx;
        @(negedge clock);
        dur_moer     = d1[W-1:0];
        dur_aquecer  = d2[W-1:0];
        dur_despejar = d3[W-1:0];
        iniciar      = 1'b1;
        push_run(d1, d2, d3, p_at, p_len);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            chk(tag, obs, e);
            cancelar  = 1'b0;
            reset     = 1'b0;
            fim_forca = 1'b0;
            if (!hold || (e.est == 4'd7)) iniciar = 1'b0;
            if (muda_dur && (idx == 2)) begin
                dur_moer     = 8'd7;
                dur_aquecer  = 8'd7;
                dur_despejar = 8'd7;
            end
            if (idx == cancel_at) begin
                cancelar = 1'b1;
                iniciar  = 1'b0;
                exp_q.delete();
                exp_q.push_back(mk(4'd8, 1'b0));
                exp_q.push_back(mk(4'd0, 1'b0));
                exp_q.push_back(mk(4'd0, 1'b0));
            end
            if (idx == reset_at) begin
                reset   = 1'b1;
                iniciar = 1'b0;
                exp_q.delete();
                for (int k = 0; k < 3; k++) exp_q.push_back(mk(4'd0, 1'b0));
            end
            if ((reset_at >= 0) && (idx == reset_at + 1)) fim_forca = 1'b1;
            if ((p_len > 0) && (idx == p_at)) pausar = 1'b1;
            if ((p_len > 0) && (idx == p_at + p_len)) pausar = 1'b0;
            idx++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        repeat (3) @(negedge clock);
        exp_q.push_back(mk(4'd0, 1'b0));
        e = exp_q.pop_front();
        chk("reset", obs, e);
        reset = 1'b0;

        // iniciar and cancelar together in INICIAL must not start a run.
        @(negedge clock);
        iniciar  = 1'b1;
        cancelar = 1'b1;
        exp_q.push_back(mk(4'd0, 1'b0));
        exp_q.push_back(mk(4'd0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            e = exp_q.pop_front();
            chk("ini_cancel", obs, e);
            iniciar  = 1'b0;
            cancelar = 1'b0;
        end

        run_case("nominal",   2, 1, 3,   1'b1, 1'b1, -1, -1, 0, 0);
        run_case("zero_dur",  0, 2, 0,   1'b0, 1'b0, -1, -1, 0, 0);
        run_case("cancel",    3, 1, 1,   1'b0, 1'b0,  7, -1, 0, 0);
        run_case("reset_mid", 1, 2, 1,   1'b0, 1'b0, -1,  9, 0, 0);
        run_case("max_dur",   255, 0, 1, 1'b0, 1'b0, -1, -1, 0, 0);
`ifdef SEQUENCIADOR_PAUSA_EN
        run_case("pausa",     3, 0, 0,   1'b0, 1'b0, -1, -1, 3, 20);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
